// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the interrupt priority encoder and the
// trap-cause logic.
//   IRQ_LINES    : default number of peripheral request lines
//   penc_state_t : grant FSM state (IDLE = nothing presented, PRESENT = held for ack)
package cpu_pkg;

  localparam int IRQ_LINES = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } penc_state_t;

endpackage

// File: rtl/prio_select.sv
// Combinational priority select: index of the highest (HI_FIRST=1) or lowest
// (HI_FIRST=0) set bit of a vector.
//   vec : candidate vector
//   idx : index of the winning bit (0 when no bit is set)
//   any : at least one bit of vec is set
module prio_select #(
  parameter int N_IN     = 8,
  parameter bit HI_FIRST = 1'b1,
  localparam int W       = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] vec,
  output logic [W-1:0]    idx,
  output logic            any
);

  // The scan direction is chosen so that the last hit overwrites earlier
  // ones; the winner is whichever end of the vector has priority.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it
    // unassigned and no latch is inferred.
    idx = '0;
    any = 1'b0;
    if (HI_FIRST) begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec[i]) begin
          idx = W'(i);
          any = 1'b1;
        end
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = W'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// Registered interrupt priority encoder with per-line pending latches, masking
// and a valid/ack handshake toward the CPU control unit.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req       : peripheral request lines
//   mask      : 1 = line masked (still latched, never selected)
//   ack       : consumer accepts out_code (only meaningful while out_valid)
//   out_code  : index of the granted line, held until ack
//   out_valid : out_code is valid
//   pending   : current pending vector
//   overrun   : 1-cycle pulse, a new edge hit a line that was already pending
module prio_irq_encoder
  import cpu_pkg::*;
#(
  parameter int N_IN     = IRQ_LINES,
  parameter bit EDGE     = 1'b1,
  parameter bit HI_FIRST = 1'b1,
  localparam int W       = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] mask,
  input  logic            ack,
  output logic [W-1:0]    out_code,
  output logic            out_valid,
  output logic [N_IN-1:0] pending,
  output logic            overrun
);

  penc_state_t     state_q;
  logic [N_IN-1:0] req_q;
  logic [N_IN-1:0] pending_q, pending_d;
  logic [W-1:0]    out_code_q;
  logic            out_valid_q;
  logic            overrun_q, overrun_d;

  logic [N_IN-1:0] edge_v;
  logic [N_IN-1:0] clr;
  logic [N_IN-1:0] elig;
  logic [W-1:0]    winner;
  logic            any_elig;

  assign edge_v = req & ~req_q;
  assign elig   = pending_q & ~mask;

  // Only an acknowledged grant clears its line; ack outside PRESENT is ignored.
  always_comb begin
    clr = '0;
    if (state_q == PRESENT && ack) clr[out_code_q] = 1'b1;
  end

  // Set wins over clear, so an edge arriving with the ack re-arms the line.
  always_comb begin
    if (EDGE) begin
      pending_d = edge_v | (pending_q & ~clr);
      overrun_d = |(edge_v & pending_q & ~clr);
    end else begin
      pending_d = req;
      overrun_d = 1'b0;
    end
  end

  prio_select #(
    .N_IN     (N_IN),
    .HI_FIRST (HI_FIRST)
  ) u_select (
    .vec (elig),
    .idx (winner),
    .any (any_elig)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and the evaluation order of the statements is irrelevant.
  always_ff @(posedge clk) begin
    // NOTE: all state here is a handful of flops, so every one is reset;
    // req_q at zero makes a line held through reset count as a fresh edge.
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      unique case (state_q)
        IDLE: begin
          if (any_elig) begin
            out_code_q  <= winner;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          // Grant is frozen here; mask or request changes cannot retract it.
          if (ack) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench for prio_irq_encoder. Three instances share stimulus:
// edge/high-first, edge/low-first and level/high-first.
module tb_prio_irq_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;

  logic [2:0] hi_code, lo_code, lv_code;
  logic       hi_valid, lo_valid, lv_valid;
  logic [7:0] hi_pend, lo_pend, lv_pend;
  logic       hi_ovr, lo_ovr, lv_ovr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prio_irq_encoder #(.N_IN(8), .EDGE(1'b1), .HI_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .out_code(hi_code), .out_valid(hi_valid), .pending(hi_pend), .overrun(hi_ovr)
  );

  prio_irq_encoder #(.N_IN(8), .EDGE(1'b1), .HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .out_code(lo_code), .out_valid(lo_valid), .pending(lo_pend), .overrun(lo_ovr)
  );

  prio_irq_encoder #(.N_IN(8), .EDGE(1'b0), .HI_FIRST(1'b1)) dut_lv (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .out_code(lv_code), .out_valid(lv_valid), .pending(lv_pend), .overrun(lv_ovr)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h01; mask = '0; ack = 1'b0;
    tick(); tick();
    tests_run++;
    if ({hi_valid, hi_code, hi_pend, hi_ovr} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b code=%0d pend=%h ovr=%b, want all 0",
               hi_valid, hi_code, hi_pend, hi_ovr);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (hi_pend !== 8'h01 || hi_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held_edge: got pend=%h valid=%b, want 01/0", hi_pend, hi_valid);
    end
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd0) begin
      tests_failed++;
      $display("FAIL first_grant: got valid=%b code=%0d, want 1/0", hi_valid, hi_code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h00) begin
      tests_failed++;
      $display("FAIL first_ack: got valid=%b pend=%h, want 0/00", hi_valid, hi_pend);
    end
    req = '0;
  endtask

  task automatic test_priority();
    do_reset();
    req = 8'h28; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd5 || lo_valid !== 1'b1 || lo_code !== 3'd3) begin
      tests_failed++;
      $display("FAIL prio_first: got hi=%b/%0d lo=%b/%0d, want 1/5 1/3",
               hi_valid, hi_code, lo_valid, lo_code);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h08 || lo_valid !== 1'b0 || lo_pend !== 8'h20) begin
      tests_failed++;
      $display("FAIL prio_bubble: got hi=%b/%h lo=%b/%h, want 0/08 0/20",
               hi_valid, hi_pend, lo_valid, lo_pend);
    end
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd3 || lo_valid !== 1'b1 || lo_code !== 3'd5) begin
      tests_failed++;
      $display("FAIL prio_second: got hi=%b/%0d lo=%b/%0d, want 1/3 1/5",
               hi_valid, hi_code, lo_valid, lo_code);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    tests_run++;
    if (hi_pend !== 8'h00 || lo_pend !== 8'h00 || hi_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_drain: got hi_pend=%h lo_pend=%h valid=%b, want 00/00/0",
               hi_pend, lo_pend, hi_valid);
    end
  endtask

  task automatic test_mask();
    do_reset();
    mask = 8'h80;
    req = 8'h80; tick();
    req = 8'h00; ack = 1'b1; tick(); ack = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h80) begin
      tests_failed++;
      $display("FAIL mask_hold: got valid=%b pend=%h, want 0/80", hi_valid, hi_pend);
    end
    req = 8'h02; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd1 || hi_pend !== 8'h82) begin
      tests_failed++;
      $display("FAIL mask_grant1: got valid=%b code=%0d pend=%h, want 1/1/82",
               hi_valid, hi_code, hi_pend);
    end
    mask = 8'h00;
    ack = 1'b1; tick(); ack = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h80) begin
      tests_failed++;
      $display("FAIL mask_ack1: got valid=%b pend=%h, want 0/80", hi_valid, hi_pend);
    end
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd7) begin
      tests_failed++;
      $display("FAIL mask_unmask: got valid=%b code=%0d, want 1/7", hi_valid, hi_code);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_freeze();
    do_reset();
    req = 8'h04; tick();
    req = 8'h00; tick();
    req = 8'h40; mask = 8'h04; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd2 || hi_pend !== 8'h44) begin
      tests_failed++;
      $display("FAIL freeze_hold: got valid=%b code=%0d pend=%h, want 1/2/44",
               hi_valid, hi_code, hi_pend);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd6 || hi_pend !== 8'h40) begin
      tests_failed++;
      $display("FAIL freeze_next: got valid=%b code=%0d pend=%h, want 1/6/40",
               hi_valid, hi_code, hi_pend);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    mask = 8'h00;
  endtask

  task automatic test_overrun();
    do_reset();
    req = 8'h10; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd4 || hi_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_grant: got valid=%b code=%0d ovr=%b, want 1/4/0",
               hi_valid, hi_code, hi_ovr);
    end
    req = 8'h10; tick();
    tests_run++;
    if (hi_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_pulse: got ovr=%b, want 1", hi_ovr);
    end
    req = 8'h00; tick();
    tests_run++;
    if (hi_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_width: got ovr=%b, want 0", hi_ovr);
    end
    req = 8'h10; ack = 1'b1; tick();
    req = 8'h00; ack = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h10 || hi_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_set_beats_clr: got valid=%b pend=%h ovr=%b, want 0/10/0",
               hi_valid, hi_pend, hi_ovr);
    end
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd4) begin
      tests_failed++;
      $display("FAIL ovr_regrant: got valid=%b code=%0d, want 1/4", hi_valid, hi_code);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_ack_held();
    do_reset();
    req = 8'h06; ack = 1'b1; tick();
    req = 8'h00; tick();
    tick();
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h02) begin
      tests_failed++;
      $display("FAIL ack_held_one: got valid=%b pend=%h, want 0/02", hi_valid, hi_pend);
    end
    tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd1) begin
      tests_failed++;
      $display("FAIL ack_held_next: got valid=%b code=%0d, want 1/1", hi_valid, hi_code);
    end
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'hFF; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd7 || hi_pend !== 8'hFF) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got valid=%b code=%0d pend=%h, want 1/7/FF",
               hi_valid, hi_code, hi_pend);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++;
    if (hi_valid !== 1'b0 || hi_pend !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got valid=%b pend=%h, want 0/00", hi_valid, hi_pend);
    end
    tick(); tick(); tick();
    tests_run++;
    if (hi_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got valid=%b, want 0", hi_valid);
    end
    req = 8'h01; tick();
    req = 8'h00; tick();
    tests_run++;
    if (hi_valid !== 1'b1 || hi_code !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_new: got valid=%b code=%0d, want 1/0", hi_valid, hi_code);
    end
  endtask

  task automatic test_level();
    do_reset();
    req = 8'h10; tick();
    tick();
    tests_run++;
    if (lv_valid !== 1'b1 || lv_code !== 3'd4) begin
      tests_failed++;
      $display("FAIL level_grant: got valid=%b code=%0d, want 1/4", lv_valid, lv_code);
    end
    for (int n = 0; n < 2; n++) begin
      ack = 1'b1; tick(); ack = 1'b0;
      tests_run++;
      if (lv_valid !== 1'b0 || lv_pend !== 8'h10) begin
        tests_failed++;
        $display("FAIL level_ack%0d: got valid=%b pend=%h, want 0/10", n, lv_valid, lv_pend);
      end
      tick();
      tests_run++;
      if (lv_valid !== 1'b1 || lv_code !== 3'd4 || lv_ovr !== 1'b0) begin
        tests_failed++;
        $display("FAIL level_repeat%0d: got valid=%b code=%0d ovr=%b, want 1/4/0",
                 n, lv_valid, lv_code, lv_ovr);
      end
    end
    req = 8'h00;
    ack = 1'b1; tick(); ack = 1'b0;
    tick(); tick();
    tests_run++;
    if (lv_valid !== 1'b0 || lv_pend !== 8'h00) begin
      tests_failed++;
      $display("FAIL level_drop: got valid=%b pend=%h, want 0/00", lv_valid, lv_pend);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
    test_reset();
    test_priority();
    test_mask();
    test_freeze();
    test_overrun();
    test_ack_held();
    test_reset_mid();
    test_level();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
